// File: rtl/cr_huf_comp_mc_fifo_pkg.sv
// Shared constants and width helpers for the multi-channel Huffman compressor FIFO.
package cr_huf_comp_mc_fifo_pkg;
  localparam int RD_LATENCY = 1;
  localparam int DEF_NUM_CH = 4;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

  typedef logic [ch_w(DEF_NUM_CH)-1:0] ch_idx_t;
endpackage

// File: rtl/cr_huf_comp_mc_fifo_chan_ctrl.sv
// Per-channel pointer/occupancy tracker; flags are registered from the next count.
module cr_huf_comp_mc_fifo_chan_ctrl #(
  parameter int DEPTH_PER_CH = 256,
  parameter int AFULL_TH     = DEPTH_PER_CH - 8,
  parameter int PTR_W        = 8,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_acc_i,
  input  logic             rd_acc_i,
  input  logic             clear_i,
  output logic [PTR_W-1:0] wptr_o,
  output logic [PTR_W-1:0] rptr_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             afull_o
);
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, full_q, afull_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_acc_i) wptr_d = wptr_q + PTR_W'(1);
      if (rd_acc_i) rptr_d = rptr_q + PTR_W'(1);
      // Simultaneous read and write leave the count unchanged.
      if (wr_acc_i && !rd_acc_i)      cnt_d = cnt_q + CNT_W'(1);
      else if (rd_acc_i && !wr_acc_i) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_W'(DEPTH_PER_CH));
      afull_q <= (cnt_d >= CNT_W'(AFULL_TH));
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign cnt_o   = cnt_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign afull_o = afull_q;
endmodule

// File: rtl/nx_ram_2rw.sv
// Behavioural 2-port RAM: port a reads with a registered output, port b writes.
// The output register only updates on a read, so data holds between reads.
module nx_ram_2rw #(
  parameter int WIDTH      = 75,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rea,
  input  logic [ADDR_W-1:0] addra,
  output logic [WIDTH-1:0]  douta,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [WIDTH-1:0]  dinb,
  input  logic              bimc_isync,
  input  logic              bimc_idat,
  output logic              bimc_osync,
  output logic              bimc_odat
);
  logic [WIDTH-1:0] mem [DEPTH];

  if (RD_LATENCY != 1) begin : g_bad_lat
    $error("nx_ram_2rw: only RD_LATENCY=1 is modelled");
  end

  always_ff @(posedge clk) begin
    if (web) mem[addrb] <= dinb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta      <= '0;
      bimc_osync <= 1'b0;
      bimc_odat  <= 1'b0;
    end else begin
      if (rea) douta <= mem[addra];
      bimc_osync <= bimc_isync;
      bimc_odat  <= bimc_idat;
    end
  end
endmodule

// File: rtl/cr_huf_comp_mc_fifo.sv
// NUM_CH logical FIFOs statically partitioned over one shared 2-port RAM,
// one tagged write and one tagged read per cycle, per-channel flags and clear.
module cr_huf_comp_mc_fifo
  import cr_huf_comp_mc_fifo_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEPTH_PER_CH = 256,
  parameter int WIDTH        = 75,
  parameter int AFULL_TH     = DEPTH_PER_CH - 8,
  parameter int CH_W         = ch_w(NUM_CH),
  parameter int CNT_W        = cnt_w(DEPTH_PER_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wen,
  input  logic [CH_W-1:0]         wch,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    ren,
  input  logic [CH_W-1:0]         rch,
  input  logic [NUM_CH-1:0]       clear,
  output logic                    rvalid,
  output logic [CH_W-1:0]         rch_out,
  output logic [WIDTH-1:0]        rdata,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       afull,
  output logic [NUM_CH*CNT_W-1:0] used_slots,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    bimc_isync,
  input  logic                    bimc_idat,
  output logic                    bimc_osync,
  output logic                    bimc_odat
);
  localparam int PTR_W = $clog2(DEPTH_PER_CH);
  localparam int AW    = CH_W + PTR_W;

  if ((DEPTH_PER_CH & (DEPTH_PER_CH - 1)) != 0) begin : g_bad_depth
    $error("cr_huf_comp_mc_fifo: DEPTH_PER_CH must be a power of 2");
  end

  logic [NUM_CH-1:0]            wr_acc, rd_acc;
  logic [NUM_CH-1:0][PTR_W-1:0] wptr, rptr;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic                         ovf_d, unf_d;
  logic                         rvalid_q, ovf_q, unf_q;
  logic [CH_W-1:0]              rch_q;

  always_comb begin
    wr_acc      = '0;
    rd_acc      = '0;
    wr_acc[wch] = wen && !full[wch] && !clear[wch];
    rd_acc[rch] = ren && !empty[rch] && !clear[rch];
    ovf_d       = wen && full[wch] && !clear[wch];
    unf_d       = ren && empty[rch] && !clear[rch];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cr_huf_comp_mc_fifo_chan_ctrl #(
      .DEPTH_PER_CH(DEPTH_PER_CH), .AFULL_TH(AFULL_TH), .PTR_W(PTR_W), .CNT_W(CNT_W)
    ) u_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_acc_i(wr_acc[c]),
      .rd_acc_i(rd_acc[c]),
      .clear_i (clear[c]),
      .wptr_o  (wptr[c]),
      .rptr_o  (rptr[c]),
      .cnt_o   (cnt[c]),
      .empty_o (empty[c]),
      .full_o  (full[c]),
      .afull_o (afull[c])
    );
    assign used_slots[c*CNT_W +: CNT_W] = cnt[c];
  end

  nx_ram_2rw #(
    .WIDTH(WIDTH), .DEPTH(NUM_CH*DEPTH_PER_CH), .ADDR_W(AW), .RD_LATENCY(RD_LATENCY)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .rea       (|rd_acc),
    .addra     ({rch, rptr[rch]}),
    .douta     (rdata),
    .web       (|wr_acc),
    .addrb     ({wch, wptr[wch]}),
    .dinb      (wdata),
    .bimc_isync(bimc_isync),
    .bimc_idat (bimc_idat),
    .bimc_osync(bimc_osync),
    .bimc_odat (bimc_odat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rch_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rvalid_q <= |rd_acc;
      if (|rd_acc) rch_q <= rch;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rch_out   = rch_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && wen) assert (int'(wch) < NUM_CH) else $error("wch out of range");
    if (rst_n && ren) assert (int'(rch) < NUM_CH) else $error("rch out of range");
  end
`endif
endmodule

// File: tb/tb_cr_huf_comp_mc_fifo.sv
// Queue-based reference model of the multi-channel FIFO driven by directed and random traffic.
module tb_cr_huf_comp_mc_fifo;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 256;
  localparam int WIDTH  = 75;
  localparam int AFULL  = DEPTH - 8;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    wen, ren;
  logic [CH_W-1:0]         wch, rch;
  logic [WIDTH-1:0]        wdata;
  logic [NUM_CH-1:0]       clear;
  logic                    rvalid, overflow, underflow;
  logic [CH_W-1:0]         rch_out;
  logic [WIDTH-1:0]        rdata;
  logic [NUM_CH-1:0]       empty, full, afull;
  logic [NUM_CH*CNT_W-1:0] used_slots;
  logic                    bimc_isync, bimc_idat, bimc_osync, bimc_odat;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] q [NUM_CH][$];
  logic [WIDTH-1:0] last_rd;

  cr_huf_comp_mc_fifo dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wch(wch), .wdata(wdata),
    .ren(ren), .rch(rch), .clear(clear), .rvalid(rvalid), .rch_out(rch_out),
    .rdata(rdata), .empty(empty), .full(full), .afull(afull),
    .used_slots(used_slots), .overflow(overflow), .underflow(underflow),
    .bimc_isync(bimc_isync), .bimc_idat(bimc_idat),
    .bimc_osync(bimc_osync), .bimc_odat(bimc_odat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_flags();
    for (int c = 0; c < NUM_CH; c++) begin
      int n;
      n = q[c].size();
      chk($sformatf("empty[%0d]", c), empty[c], n == 0);
      chk($sformatf("full[%0d]", c),  full[c],  n == DEPTH);
      chk($sformatf("afull[%0d]", c), afull[c], n >= AFULL);
      chk($sformatf("used[%0d]", c),  used_slots[c*CNT_W +: CNT_W], n);
    end
  endtask

  // Drive one cycle of requests at the falling edge, advance the model, check after the rising edge.
  task automatic cycle(input bit w, input int wc, input bit r, input int rc,
                       input logic [NUM_CH-1:0] clr);
    logic [WIDTH-1:0] wd;
    bit wacc, racc, eovf, eunf;
    wd    = rnd_data();
    wen   = w;  wch = CH_W'(wc);  wdata = wd;
    ren   = r;  rch = CH_W'(rc);  clear = clr;
    wacc = w && q[wc].size() < DEPTH && !clr[wc];
    eovf = w && q[wc].size() == DEPTH && !clr[wc];
    racc = r && q[rc].size() > 0 && !clr[rc];
    eunf = r && q[rc].size() == 0 && !clr[rc];
    if (racc) last_rd = q[rc].pop_front();
    if (wacc) q[wc].push_back(wd);
    for (int c = 0; c < NUM_CH; c++) if (clr[c]) q[c].delete();
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; clear = '0;
    chk("rvalid", rvalid, racc);
    if (racc) chk("rch_out", rch_out, rc);
    chk("rdata", rdata, last_rd);
    chk("overflow", overflow, eovf);
    chk("underflow", underflow, eunf);
    chk_flags();
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_empty", empty, {NUM_CH{1'b1}});
    chk("rst_used", used_slots, '0);
    chk("rst_rdata", rdata, '0);
    for (int c = 0; c < NUM_CH; c++) q[c].delete();
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0; wch = '0; rch = '0; wdata = '0; clear = '0;
    bimc_isync = 1'b0; bimc_idat = 1'b0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    chk("reset_unf", underflow, 1'b0);
    chk("reset_rch_out", rch_out, '0);
    chk("reset_rdata", rdata, '0);
    chk_flags();
    rst_n = 1'b1;

    // Basic in-order write then read on ch0.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, '0);

    // Fill ch2 to full, overflow, and ch1 still accepts.
    for (int i = 0; i < DEPTH; i++) cycle(1, 2, 0, 0, '0);
    cycle(1, 2, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);

    // Read+write same channel while full, then at DEPTH-1.
    cycle(1, 2, 1, 2, '0);
    cycle(1, 2, 1, 2, '0);

    // Wrap ch3 pointers with interleaved traffic at depth 10.
    for (int i = 0; i < 10; i++) cycle(1, 3, 0, 0, '0);
    for (int i = 0; i < 290; i++) cycle(1, 3, 1, 3, '0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 3, '0);

    // Underflow on empty ch1, then write colliding with clear.
    cycle(0, 0, 1, 1, '0);
    cycle(0, 0, 1, 1, '0);
    cycle(1, 1, 0, 0, 4'b0010);
    // Read issued the cycle before a clear still returns.
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, '0);
    cycle(0, 0, 0, 0, 4'b0001);

    // Mid-stream reset, then fresh traffic.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, '0);
      cycle(1, 1, 0, 0, '0);
    end
    cycle(1, 0, 1, 1, '0);
    mid_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, '0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0] clr;
      for (int c = 0; c < NUM_CH; c++) clr[c] = ($urandom_range(0, 99) == 0);
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, NUM_CH-1),
            $urandom_range(0, 9) < 5, $urandom_range(0, NUM_CH-1), clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
